// File: rtl/rv32im_ras.sv
// Return address stack for an RV32IM front end.
// Circular LIFO of DEPTH link addresses. A push advances the top-of-stack
// pointer and writes there; once full, the next push wraps onto the oldest
// entry and flags overflow. A pop presents entry[tos] on predict_o one
// cycle later. A push together with a pop (a call and a return in the same
// cycle) swaps the top entry in place.
module rv32im_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     clear_i,
    input  logic                     valid_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [XLEN-1:0]          push_data_i,
    input  logic                     flush_i,
    output logic [XLEN-1:0]          predict_o,
    output logic                     predict_valid_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   tos_q, tos_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] predict_q, predict_d;
    logic            pvalid_q, pvalid_d;
    logic            ovf_q, ovf_d;
    logic            we;
    logic [PW-1:0]   waddr;

    // Next-state decode: clear beats flush beats a qualified push/pop.
    always_comb begin
        tos_d     = tos_q;
        count_d   = count_q;
        predict_d = predict_q;
        pvalid_d  = 1'b0;
        ovf_d     = 1'b0;
        we        = 1'b0;
        waddr     = tos_q;
        if (clear_i) begin
            tos_d     = '0;
            count_d   = '0;
            predict_d = '0;
        end else if (flush_i) begin
            tos_d   = '0;
            count_d = '0;
        end else if (valid_i) begin
            if (pop_i && (count_q != '0)) begin
                predict_d = mem_q[tos_q];
                pvalid_d  = 1'b1;
                if (push_i) begin
                    // Call and return together: replace the top entry in place.
                    we    = 1'b1;
                    waddr = tos_q;
                end else begin
                    tos_d   = tos_q - PTR_ONE;
                    count_d = count_q - CNT_ONE;
                end
            end else if (push_i) begin
                // Also covers push+pop on an empty stack, where the pop has nothing to return.
                tos_d = tos_q + PTR_ONE;
                we    = 1'b1;
                waddr = tos_q + PTR_ONE;
                if (count_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
        end
    end

    // Control and prediction registers with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            tos_q     <= '0;
            count_q   <= '0;
            predict_q <= '0;
            pvalid_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            tos_q     <= tos_d;
            count_q   <= count_d;
            predict_q <= predict_d;
            pvalid_q  <= pvalid_d;
            ovf_q     <= ovf_d;
        end
    end

    // Entry storage is never reset; entries are unreachable while count is zero.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= push_data_i;
        end
    end

    assign predict_o       = predict_q;
    assign predict_valid_o = pvalid_q;
    assign overflow_o      = ovf_q;
    assign count_o         = count_q;
    assign empty_o         = (count_q == '0);
    assign full_o          = (count_q == CNT_MAX);

endmodule

// File: tb/tb_rv32im_ras.sv
// Directed testbench for rv32im_ras with DEPTH=8, XLEN=32.
module tb_rv32im_ras;

    logic        clk;
    logic        clear, valid, push, pop, flush;
    logic [31:0] push_data;
    logic [31:0] predict;
    logic        predict_valid, empty, full, overflow;
    logic [3:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    rv32im_ras #(.XLEN(32), .DEPTH(8)) dut (
        .clk_i           (clk),
        .clear_i         (clear),
        .valid_i         (valid),
        .push_i          (push),
        .pop_i           (pop),
        .push_data_i     (push_data),
        .flush_i         (flush),
        .predict_o       (predict),
        .predict_valid_o (predict_valid),
        .empty_o         (empty),
        .full_o          (full),
        .count_o         (count),
        .overflow_o      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive at the falling edge, return 1ns after the rising edge.
    task automatic cyc(input logic cl, input logic fl, input logic v,
                       input logic pu, input logic po, input logic [31:0] d);
        @(negedge clk);
        clear = cl; flush = fl; valid = v; push = pu; pop = po; push_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 32'h0);
        if (count !== 4'd0) begin $display("FAIL reset_count got %0d exp 0", count); n_err++; end
        n_cmp++;
        if (empty !== 1'b1 || full !== 1'b0) begin $display("FAIL reset_flags got empty=%0b full=%0b exp 1/0", empty, full); n_err++; end
        n_cmp++;
        if (predict !== 32'h0 || predict_valid !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL reset_outs got pred=%h pv=%0b ovf=%0b exp 0/0/0", predict, predict_valid, overflow); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_lifo();
        logic [31:0] exp_v;
        cyc(1, 0, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 1, 1, 0, 32'h100 * i);
            if (count !== 4'(i)) begin $display("FAIL lifo_push_count got %0d exp %0d", count, i); n_err++; end
            n_cmp++;
        end
        for (int i = 0; i < 3; i++) begin
            exp_v = 32'h300 - 32'h100 * i;
            cyc(0, 0, 1, 0, 1, 32'h0);
            if (predict !== exp_v || predict_valid !== 1'b1) begin
                $display("FAIL lifo_pop%0d got %h pv=%0b exp %h pv=1", i, predict, predict_valid, exp_v); n_err++;
            end
            n_cmp++;
        end
        if (empty !== 1'b1) begin $display("FAIL lifo_empty got %0b exp 1", empty); n_err++; end
        n_cmp++;
        cyc(0, 0, 0, 0, 0, 32'h0);
        if (predict_valid !== 1'b0 || predict !== 32'h100) begin
            $display("FAIL lifo_idle got pv=%0b pred=%h exp 0/00000100", predict_valid, predict); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_underflow();
        cyc(1, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 1, 32'h0);
        if (predict_valid !== 1'b0 || count !== 4'd0 || predict !== 32'h0) begin
            $display("FAIL underflow got pv=%0b cnt=%0d pred=%h exp 0/0/0", predict_valid, count, predict); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_overflow();
        logic [31:0] exp_v;
        cyc(1, 0, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 0, 1, 1, 0, 32'h10 * i);
            if (i == 8) begin
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    $display("FAIL ovf_full8 got full=%0b ovf=%0b exp 1/0", full, overflow); n_err++;
                end
                n_cmp++;
            end
        end
        if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
            $display("FAIL ovf_ninth got ovf=%0b cnt=%0d full=%0b exp 1/8/1", overflow, count, full); n_err++;
        end
        n_cmp++;
        cyc(0, 0, 0, 0, 0, 32'h0);
        if (overflow !== 1'b0) begin $display("FAIL ovf_pulse got %0b exp 0", overflow); n_err++; end
        n_cmp++;
        for (int i = 0; i < 8; i++) begin
            exp_v = 32'h90 - 32'h10 * i;
            cyc(0, 0, 1, 0, 1, 32'h0);
            if (predict !== exp_v || predict_valid !== 1'b1 || count !== 4'(7 - i)) begin
                $display("FAIL ovf_pop%0d got %h pv=%0b cnt=%0d exp %h pv=1 cnt=%0d",
                         i, predict, predict_valid, count, exp_v, 7 - i); n_err++;
            end
            n_cmp++;
        end
        cyc(0, 0, 1, 0, 1, 32'h0);
        if (predict_valid !== 1'b0 || predict !== 32'h20 || empty !== 1'b1) begin
            $display("FAIL ovf_pop9 got pv=%0b pred=%h empty=%0b exp 0/00000020/1", predict_valid, predict, empty); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_push_pop();
        cyc(1, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 1, 1, 0, 32'h100);
        cyc(0, 0, 1, 1, 1, 32'h400);
        if (predict !== 32'h100 || predict_valid !== 1'b1 || count !== 4'd1) begin
            $display("FAIL pp_swap got pred=%h pv=%0b cnt=%0d exp 00000100/1/1", predict, predict_valid, count); n_err++;
        end
        n_cmp++;
        cyc(0, 0, 1, 0, 1, 32'h0);
        if (predict !== 32'h400 || predict_valid !== 1'b1 || count !== 4'd0) begin
            $display("FAIL pp_pop got pred=%h pv=%0b cnt=%0d exp 00000400/1/0", predict, predict_valid, count); n_err++;
        end
        n_cmp++;
        cyc(0, 0, 1, 1, 1, 32'h500);
        if (predict_valid !== 1'b0 || count !== 4'd1) begin
            $display("FAIL pp_empty got pv=%0b cnt=%0d exp 0/1", predict_valid, count); n_err++;
        end
        n_cmp++;
        cyc(0, 0, 1, 0, 1, 32'h0);
        if (predict !== 32'h500 || predict_valid !== 1'b1) begin
            $display("FAIL pp_empty_pop got pred=%h pv=%0b exp 00000500/1", predict, predict_valid); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_flush();
        cyc(1, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 1, 1, 0, 32'h100);
        cyc(0, 0, 1, 1, 0, 32'h200);
        cyc(0, 1, 1, 1, 0, 32'h300);
        if (count !== 4'd0 || empty !== 1'b1) begin $display("FAIL flush_count got %0d exp 0", count); n_err++; end
        n_cmp++;
        cyc(0, 0, 1, 0, 1, 32'h0);
        if (predict_valid !== 1'b0 || count !== 4'd0) begin
            $display("FAIL flush_pop got pv=%0b cnt=%0d exp 0/0", predict_valid, count); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_valid_clear();
        cyc(1, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 1, 0, 32'h100);
        if (count !== 4'd0) begin $display("FAIL novalid_push got cnt=%0d exp 0", count); n_err++; end
        n_cmp++;
        cyc(0, 0, 1, 1, 0, 32'h100);
        cyc(0, 0, 1, 1, 0, 32'h150);
        cyc(0, 0, 1, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'h0);
        if (predict !== 32'h150 || predict_valid !== 1'b0 || count !== 4'd1) begin
            $display("FAIL novalid_pop got pred=%h pv=%0b cnt=%0d exp 00000150/0/1", predict, predict_valid, count); n_err++;
        end
        n_cmp++;
        cyc(1, 0, 1, 1, 0, 32'h200);
        if (count !== 4'd0 || predict !== 32'h0) begin
            $display("FAIL clear_push got cnt=%0d pred=%h exp 0/00000000", count, predict); n_err++;
        end
        n_cmp++;
        cyc(0, 0, 1, 0, 1, 32'h0);
        if (predict_valid !== 1'b0) begin $display("FAIL clear_pop got pv=%0b exp 0", predict_valid); n_err++; end
        n_cmp++;
    endtask

    initial begin
        clear = 1'b1; flush = 1'b0; valid = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        test_reset();
        test_lifo();
        test_underflow();
        test_overflow();
        test_push_pop();
        test_flush();
        test_valid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32im_ras.md
RV32IM_RAS -- requirements
Module: rv32im_ras

Interface
REQ-001 Parameter XLEN, default 32: width of stored return addresses.
REQ-002 Parameter DEPTH, default 8: entry count; SHALL be a power of two, >= 2.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 clear_i  input  1  reset; synchronous, active-high.
REQ-005 valid_i  input  1  qualifies push_i/pop_i; decoded instruction accepted this cycle.
REQ-006 push_i  input  1  push link address (call: rd is x1/x5).
REQ-007 pop_i  input  1  pop predicted return address (return: rs1 is x1/x5).
REQ-008 push_data_i  input  XLEN  link address to push (pc+4).
REQ-009 flush_i  input  1  discard all entries (pipeline redirect/trap).
REQ-010 predict_o  output  XLEN  predicted return target, registered.
REQ-011 predict_valid_o  output  1  one-cycle pulse; predict_o valid.
REQ-012 empty_o  output  1  count_o == 0.
REQ-013 full_o  output  1  count_o == DEPTH.
REQ-014 count_o  output  $clog2(DEPTH)+1  live entries, 0..DEPTH.
REQ-015 overflow_o  output  1  one-cycle pulse; push overwrote the oldest entry.

Function
REQ-016 Storage: circular array of DEPTH XLEN-bit entries; top-of-stack pointer tos, $clog2(DEPTH) bits, wraps modulo DEPTH.
REQ-017 empty_o/full_o SHALL be combinational decodes of the count register only.
REQ-018 Priority per cycle: clear_i > flush_i > qualified op (valid_i=1) > hold.
REQ-019 valid_i=0: tos, count, entries unchanged; predict_valid_o<=0; overflow_o<=0; predict_o holds.
REQ-020 Pop only, count>0: predict_o<=entry[tos], predict_valid_o<=1 next cycle (latency 1); tos<=tos-1; count<=count-1.
REQ-021 Pop only, count==0: no state change; predict_valid_o<=0; predict_o holds (underflow ignored).
REQ-022 Push only: tos<=tos+1; entry[tos+1]<=push_data_i; count<=count+1 if count<DEPTH.
REQ-023 Push only at count==DEPTH: count stays DEPTH; oldest entry overwritten by wrap; overflow_o<=1 for one cycle.
REQ-024 Push+pop, count>0: predict_o<=old entry[tos], predict_valid_o<=1; entry[tos]<=push_data_i; tos and count unchanged; no overflow.
REQ-025 Push+pop, count==0: behaves as push only (count becomes 1); predict_valid_o<=0.
REQ-026 Pointer arithmetic SHALL wrap modulo DEPTH in both directions; count never exceeds DEPTH nor drops below 0.
REQ-027 flush_i=1: count<=0, tos<=0, predict_valid_o<=0, overflow_o<=0; coincident push/pop ignored; entries need not be cleared.
REQ-028 After flush, pops SHALL NOT return stale pre-flush entries (empty until next push).
REQ-029 predict_valid_o and overflow_o SHALL never remain high two consecutive cycles without a new qualifying op.

Reset
REQ-030 clear_i=1 at a clock edge: tos<=0, count<=0, predict_o<=0, predict_valid_o<=0, overflow_o<=0; effective from the next cycle.
REQ-031 clear_i asserted mid-sequence discards all pending stack contents; push/pop in the same cycle ignored.
REQ-032 Entry array contents are not reset; unreachable while count==0.

Verification (DEPTH=8, XLEN=32)
REQ-033 Push 0x100,0x200,0x300 then 3 pops -> predict_o 0x300,0x200,0x100 each with predict_valid_o=1 one cycle after its pop; empty_o=1 at end.
REQ-034 Pop on empty after reset -> predict_valid_o=0, count_o=0, predict_o=0.
REQ-035 Push 9 values 0x10..0x90 -> full_o=1 after 8th, overflow_o pulses on 9th, count_o=8; 8 pops return 0x90..0x20; 9th pop gives predict_valid_o=0.
REQ-036 Push 0x100, then push+pop with data 0x400 -> predict_o=0x100 valid, count_o=1; next pop -> 0x400.
REQ-037 Push 0x100,0x200, flush_i with push_i -> count_o=0; following pop -> predict_valid_o=0.
REQ-038 Push 0x100 with valid_i=0 -> count_o stays 0; clear_i during push 0x200 after one push -> count_o=0, predict_o=0.
